// File: rtl/mul_accum.sv
// mul_accum: multiply-accumulate reduction stage.
// Sums COUNT consecutive accepted unsigned products into an ACCWIDTH-wide
// accumulator. Each completed sum is held on a registered output under a
// valid/ready handshake, together with a sticky carry-out flag.
//
// Ports:
//   Clk       - clock; all state changes on the rising edge
//   Rst       - asynchronous active-low reset
//   prod      - unsigned product from the MUL stage (DATAWIDTH bits)
//   in_valid  - prod is valid this cycle
//   in_ready  - block can accept a term (decoded from state only)
//   clr       - synchronous clear of partial sum and pending result
//   sum       - completed accumulation result (ACCWIDTH bits)
//   out_valid - sum is valid
//   out_ready - consumer accepts sum
//   ovf       - a carry out of ACCWIDTH occurred while building this result
//   term_cnt  - terms accepted toward the current result
module mul_accum #(
  parameter int DATAWIDTH = 2,
  parameter int ACCWIDTH  = 8,
  parameter int COUNT     = 4,
  parameter int CNTWIDTH  = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] prod,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clr,
  output logic [ACCWIDTH-1:0]  sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf,
  output logic [CNTWIDTH-1:0]  term_cnt
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [CNTWIDTH-1:0] LAST_CNT = CNTWIDTH'(COUNT - 1);

  state_t                state_r, state_s;
  logic [ACCWIDTH-1:0]   acc_r, acc_s;
  logic [CNTWIDTH-1:0]   cnt_r, cnt_s;
  logic                  ovf_acc_r, ovf_acc_s;
  logic [ACCWIDTH-1:0]   sum_r, sum_s;
  logic                  ovf_r, ovf_s;
  logic                  out_valid_r, out_valid_s;

  // One bit wider than the accumulator so the carry out is visible.
  logic [ACCWIDTH:0]     total_s;

  assign total_s = {1'b0, acc_r} + {{(ACCWIDTH + 1 - DATAWIDTH){1'b0}}, prod};

  // Next-state and datapath update; clr overrides accept and output handshake.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    ovf_acc_s   = ovf_acc_r;
    sum_s       = sum_r;
    ovf_s       = ovf_r;
    out_valid_s = out_valid_r;

    if (clr) begin
      state_s     = ST_ACC;
      acc_s       = {ACCWIDTH{1'b0}};
      cnt_s       = {CNTWIDTH{1'b0}};
      ovf_acc_s   = 1'b0;
      sum_s       = {ACCWIDTH{1'b0}};
      ovf_s       = 1'b0;
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (in_valid) begin
            if (cnt_r == LAST_CNT) begin
              // Final term goes straight to the result register.
              sum_s       = total_s[ACCWIDTH-1:0];
              ovf_s       = ovf_acc_r | total_s[ACCWIDTH];
              out_valid_s = 1'b1;
              acc_s       = {ACCWIDTH{1'b0}};
              cnt_s       = {CNTWIDTH{1'b0}};
              ovf_acc_s   = 1'b0;
              state_s     = ST_HOLD;
            end else begin
              acc_s       = total_s[ACCWIDTH-1:0];
              ovf_acc_s   = ovf_acc_r | total_s[ACCWIDTH];
              cnt_s       = cnt_r + CNTWIDTH'(1);
            end
          end else begin
            state_s = ST_ACC;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_s = 1'b0;
            state_s     = ST_ACC;
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s = ST_ACC;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r     <= ST_ACC;
      acc_r       <= {ACCWIDTH{1'b0}};
      cnt_r       <= {CNTWIDTH{1'b0}};
      ovf_acc_r   <= 1'b0;
      sum_r       <= {ACCWIDTH{1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      ovf_acc_r   <= ovf_acc_s;
      sum_r       <= sum_s;
      ovf_r       <= ovf_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign in_ready  = (state_r == ST_ACC);
  assign sum       = sum_r;
  assign ovf       = ovf_r;
  assign out_valid = out_valid_r;
  assign term_cnt  = cnt_r;

endmodule

// File: tb/tb_mul_accum.sv
// tb_mul_accum: directed plus randomized bench for mul_accum.
// The reference model keeps the accepted terms of the current result in a
// queue and forms the result from their plain integer total.
module tb_mul_accum;

  localparam int DW = 4;
  localparam int AW = 5;
  localparam int CN = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] prod;
  logic          in_valid;
  logic          in_ready;
  logic          clr;
  logic [AW-1:0] sum;
  logic          out_valid;
  logic          out_ready;
  logic          ovf;
  logic [CW-1:0] term_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state.
  int m_terms[$];
  int m_sum;
  bit m_ovf;
  bit m_valid;
  bit m_hold;

  mul_accum #(
    .DATAWIDTH(DW),
    .ACCWIDTH (AW),
    .COUNT    (CN),
    .CNTWIDTH (CW)
  ) dut (
    .Clk      (clk),
    .Rst      (rst_n),
    .prod     (prod),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clr      (clr),
    .sum      (sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .term_cnt (term_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_terms.delete();
    m_sum   = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_hold  = 1'b0;
  endtask

  // Result of COUNT terms: total modulo 2^AW; a carry happened iff total >= 2^AW.
  task automatic model_step(input bit v, input int p, input bit c, input bit r);
    int total;
    if (c) begin
      model_reset();
    end else if (!m_hold) begin
      if (v) begin
        m_terms.push_back(p);
        if (m_terms.size() == CN) begin
          total = 0;
          foreach (m_terms[i]) total += m_terms[i];
          m_sum   = total % (1 << AW);
          m_ovf   = (total >= (1 << AW));
          m_valid = 1'b1;
          m_hold  = 1'b1;
          m_terms.delete();
        end
      end
    end else if (r) begin
      m_valid = 1'b0;
      m_hold  = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sum"},       32'(sum),       32'(m_sum));
    check({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".in_ready"},  32'(in_ready),  32'(!m_hold));
    check({tag, ".term_cnt"},  32'(term_cnt),  32'(m_terms.size()));
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare 1 time unit later.
  task automatic cycle(input string tag, input bit v, input int p, input bit c, input bit r);
    in_valid  = v;
    prod      = DW'(p);
    clr       = c;
    out_ready = r;
    @(posedge clk);
    model_step(v, p, c, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    int seq1[4] = '{3, 5, 7, 2};
    int seq5[7] = '{2, -1, -1, 3, -1, 4, 5};
    int seq6[4] = '{1, 2, 3, 4};
    int cnt5[6] = '{1, 1, 1, 2, 2, 3};

    rst_n = 1'b0; prod = '0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    #5;

    // 1. Basic sum with out_ready high.
    for (int i = 0; i < 4; i++) cycle("basic", 1'b1, seq1[i], 1'b0, 1'b1);
    check("basic.sum17", 32'(sum), 32'd17);
    check("basic.ovf0", 32'(ovf), 32'd0);
    check("basic.in_ready_low", 32'(in_ready), 32'd0);
    cycle("basic.drain", 1'b0, 0, 1'b0, 1'b1);
    check("basic.in_ready_back", 32'(in_ready), 32'd1);

    // 2. Overflow, then a clean run shows the sticky flag was cleared.
    for (int i = 0; i < 4; i++) cycle("ovf", 1'b1, 15, 1'b0, 1'b1);
    check("ovf.sum28", 32'(sum), 32'd28);
    check("ovf.flag", 32'(ovf), 32'd1);
    cycle("ovf.drain", 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("ovf2", 1'b1, 1, 1'b0, 1'b1);
    check("ovf2.sum4", 32'(sum), 32'd4);
    check("ovf2.flag", 32'(ovf), 32'd0);
    cycle("ovf2.drain", 1'b0, 0, 1'b0, 1'b1);

    // 3. Backpressure: result held while in_valid pulses are ignored.
    for (int i = 0; i < 4; i++) cycle("bp.fill", 1'b1, seq1[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("bp.hold", (i % 2) == 0, 9, 1'b0, 1'b0);
    check("bp.sum17", 32'(sum), 32'd17);
    check("bp.term_cnt0", 32'(term_cnt), 32'd0);
    cycle("bp.release", 1'b0, 0, 1'b0, 1'b1);
    check("bp.out_valid0", 32'(out_valid), 32'd0);
    cycle("bp.after", 1'b0, 0, 1'b0, 1'b1);

    // 4. Clear mid-run drops the partial sum and the concurrent term.
    cycle("clr.a", 1'b1, 4, 1'b0, 1'b1);
    cycle("clr.b", 1'b1, 4, 1'b0, 1'b1);
    check("clr.term_cnt2", 32'(term_cnt), 32'd2);
    cycle("clr.hit", 1'b1, 6, 1'b1, 1'b1);
    check("clr.term_cnt0", 32'(term_cnt), 32'd0);
    for (int i = 0; i < 4; i++) cycle("clr.run", 1'b1, 1, 1'b0, 1'b1);
    check("clr.sum4", 32'(sum), 32'd4);
    cycle("clr.drain", 1'b0, 0, 1'b0, 1'b1);

    // 5. Gapped input; -1 marks an idle cycle.
    for (int i = 0; i < 7; i++) begin
      cycle("gap", seq5[i] >= 0, (seq5[i] >= 0) ? seq5[i] : 0, 1'b0, 1'b0);
      if (i < 6) check("gap.term_cnt", 32'(term_cnt), 32'(cnt5[i]));
    end
    check("gap.sum14", 32'(sum), 32'd14);
    check("gap.valid", 32'(out_valid), 32'd1);
    cycle("gap.drain", 1'b0, 0, 1'b0, 1'b1);

    // 6. Asynchronous reset while holding a result.
    for (int i = 0; i < 4; i++) cycle("ar.fill", 1'b1, seq1[i], 1'b0, 1'b0);
    check("ar.sum17", 32'(sum), 32'd17);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("ar.async");
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("ar.run", 1'b1, seq6[i], 1'b0, 1'b1);
    check("ar.sum10", 32'(sum), 32'd10);
    cycle("ar.drain", 1'b0, 0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            $urandom_range(0, 9) < 7,
            int'($urandom_range(0, 15)),
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
